// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage constants and FSM state type for the program-counter generator.
package pc_gen_pkg;

    localparam int unsigned INST_ADDR_W  = 32;
    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic        RST_ENABLE   = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Low-order bits that must be zero for an instruction-aligned address.
    function automatic logic [INST_ADDR_W-1:0] align_mask(input int unsigned inst_bytes);
        return INST_ADDR_W'(inst_bytes - 1);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/fetch bus between pipeline controller and the PC generator.
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic              br_valid;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] pc;
    logic              ce;
    logic              redir_pend;
    logic              misalign;

    modport master (
        input  stall, flush, br_valid, br_target,
        output pc, ce, redir_pend, misalign
    );

    modport slave (
        output stall, flush, br_valid, br_target,
        input  pc, ce, redir_pend, misalign
    );
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// One-entry buffer holding a branch target that arrived while the fetch stage was stalled.
module pc_redirect_buf #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              pend_valid_o,
    output logic [ADDR_W-1:0] pend_target_o
);
    import pc_gen_pkg::*;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // An unstalled cycle with nothing newer to capture consumes the entry.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else if (!stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign pend_valid_o  = valid_q;
    assign pend_target_o = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: stall, branch redirect, exception flush,
// misaligned-target rejection and a buffered redirect behind stalls.
module pc_gen #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC    = 'h20
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);
    import pc_gen_pkg::*;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              misalign_q, misalign_d;

    logic              buf_capture, buf_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              br_misaligned;

    assign br_misaligned = |(bus.br_target & ALIGN_MASK);

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
        .clk           (clk),
        .rst           (rst),
        .capture_i     (buf_capture),
        .clear_i       (buf_clear),
        .stall_i       (bus.stall),
        .target_i      (bus.br_target),
        .pend_valid_o  (pend_valid),
        .pend_target_o (pend_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        misalign_d  = 1'b0;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
                ce_d    = CHIP_ENABLE;
            end
            RUN: begin
                ce_d = CHIP_ENABLE;
                if (bus.flush) begin
                    pc_d      = EXC_VEC;
                    buf_clear = 1'b1;
                end else if (bus.br_valid && br_misaligned) begin
                    pc_d       = EXC_VEC;
                    buf_clear  = 1'b1;
                    misalign_d = 1'b1;
                end else if (bus.br_valid && !bus.stall) begin
                    pc_d      = bus.br_target;
                    buf_clear = 1'b1;
                end else if (bus.br_valid) begin
                    buf_capture = 1'b1;
                end else if (!bus.stall) begin
                    pc_d = pend_valid ? pend_target : pc_q + PC_INC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            ce_q       <= CHIP_DISABLE;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ce         = ce_q;
    assign bus.misalign   = misalign_q;
    assign bus.redir_pend = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen: 32-bit instance for sequencing, 8-bit instance for wrap/async reset.
module tb_pc_gen;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        br_valid;
        logic [31:0] br_target;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    localparam int unsigned NVEC = 24;

    logic clk;
    logic rst;
    logic rst_s;
    int   checks;
    int   failures;
    vec_t vecs [NVEC];

    pc_gen_if #(.ADDR_W(32)) bus_w ();
    pc_gen_if #(.ADDR_W(8))  bus_s ();

    pc_gen #(
        .ADDR_W     (32),
        .INST_BYTES (4),
        .RESET_VEC  (32'h0000_0000),
        .EXC_VEC    (32'h0000_0020)
    ) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    pc_gen #(
        .ADDR_W     (8),
        .INST_BYTES (4),
        .RESET_VEC  (8'h40),
        .EXC_VEC    (8'h20)
    ) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic fl, input logic bv,
                                input logic [31:0] tgt, input logic [31:0] epc,
                                input logic epend, input logic emis);
        vec_t v;
        v.stall = st; v.flush = fl; v.br_valid = bv; v.br_target = tgt;
        v.exp_pc = epc; v.exp_pend = epend; v.exp_mis = emis;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //              stall flush br  target        pc            pend mis
        vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,   0, 0); // IDLE -> RUN, pc stays RESET_VEC
        vecs[1]  = mk(0, 0, 0, 32'h0,   32'h4,   0, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,   32'h8,   0, 0);
        vecs[3]  = mk(0, 0, 0, 32'h0,   32'hC,   0, 0);
        vecs[4]  = mk(0, 0, 1, 32'h100, 32'h100, 0, 0); // branch
        vecs[5]  = mk(0, 0, 0, 32'h0,   32'h104, 0, 0);
        vecs[6]  = mk(0, 0, 1, 32'h10,  32'h10,  0, 0);
        vecs[7]  = mk(1, 0, 1, 32'h200, 32'h10,  1, 0); // branch under stall
        vecs[8]  = mk(1, 0, 1, 32'h300, 32'h10,  1, 0); // newer target overwrites
        vecs[9]  = mk(1, 0, 0, 32'h0,   32'h10,  1, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,   32'h300, 0, 0); // buffered redirect applied
        vecs[11] = mk(0, 0, 0, 32'h0,   32'h304, 0, 0);
        vecs[12] = mk(1, 0, 1, 32'h500, 32'h304, 1, 0);
        vecs[13] = mk(1, 1, 1, 32'h400, 32'h20,  0, 0); // flush beats all
        vecs[14] = mk(1, 0, 0, 32'h0,   32'h20,  0, 0);
        vecs[15] = mk(0, 0, 0, 32'h0,   32'h24,  0, 0);
        vecs[16] = mk(0, 0, 1, 32'h102, 32'h20,  0, 1); // misaligned target
        vecs[17] = mk(0, 0, 0, 32'h0,   32'h24,  0, 0);
        vecs[18] = mk(1, 0, 1, 32'h600, 32'h24,  1, 0);
        vecs[19] = mk(1, 0, 1, 32'h103, 32'h20,  0, 1); // misaligned under stall clears pending
        vecs[20] = mk(0, 0, 0, 32'h0,   32'h24,  0, 0);
        vecs[21] = mk(0, 1, 1, 32'h101, 32'h20,  0, 0); // flush wins over misalign pulse
        vecs[22] = mk(1, 0, 0, 32'h0,   32'h20,  0, 0);
        vecs[23] = mk(0, 0, 0, 32'h0,   32'h24,  0, 0);

        rst   = 1'b0;
        rst_s = 1'b0;
        bus_w.stall = 1'b0; bus_w.flush = 1'b0; bus_w.br_valid = 1'b0; bus_w.br_target = '0;
        bus_s.stall = 1'b0; bus_s.flush = 1'b0; bus_s.br_valid = 1'b0; bus_s.br_target = '0;

        #1;
        chk("reset pc", bus_w.pc, 32'h0);
        chk("reset ce", 32'(bus_w.ce), 32'h0);
        repeat (3) tick();
        chk("reset held pc", bus_w.pc, 32'h0);
        chk("reset held ce", 32'(bus_w.ce), 32'h0);
        chk("reset pend", 32'(bus_w.redir_pend), 32'h0);
        chk("reset mis", 32'(bus_w.misalign), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            bus_w.stall     = vecs[i].stall;
            bus_w.flush     = vecs[i].flush;
            bus_w.br_valid  = vecs[i].br_valid;
            bus_w.br_target = vecs[i].br_target;
            tick();
            chk($sformatf("v%0d pc", i),   bus_w.pc, vecs[i].exp_pc);
            chk($sformatf("v%0d ce", i),   32'(bus_w.ce), 32'h1);
            chk($sformatf("v%0d pend", i), 32'(bus_w.redir_pend), 32'(vecs[i].exp_pend));
            chk($sformatf("v%0d mis", i),  32'(bus_w.misalign), 32'(vecs[i].exp_mis));
        end

        // 8-bit instance: wrap-around and asynchronous reset between edges
        chk("s reset pc", 32'(bus_s.pc), 32'h40);
        chk("s reset ce", 32'(bus_s.ce), 32'h0);
        rst_s = 1'b1;
        tick();
        chk("s start pc", 32'(bus_s.pc), 32'h40);
        chk("s start ce", 32'(bus_s.ce), 32'h1);
        tick();
        chk("s inc pc", 32'(bus_s.pc), 32'h44);
        bus_s.br_valid = 1'b1; bus_s.br_target = 8'hFC;
        tick();
        chk("s br pc", 32'(bus_s.pc), 32'hFC);
        bus_s.br_valid = 1'b0; bus_s.br_target = '0;
        tick();
        chk("s wrap pc", 32'(bus_s.pc), 32'h00);
        tick();
        chk("s post wrap pc", 32'(bus_s.pc), 32'h04);
        #3;
        rst_s = 1'b0;
        #1;
        chk("s async pc", 32'(bus_s.pc), 32'h40);
        chk("s async ce", 32'(bus_s.ce), 32'h0);
        tick();
        chk("s reset hold pc", 32'(bus_s.pc), 32'h40);
        chk("s reset hold ce", 32'(bus_s.ce), 32'h0);
        rst_s = 1'b1;
        tick();
        chk("s restart pc", 32'(bus_s.pc), 32'h40);
        chk("s restart ce", 32'(bus_s.ce), 32'h1);
        tick();
        chk("s restart inc pc", 32'(bus_s.pc), 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
